// File: rtl/mux_recombine.sv
// mux_recombine: merges two per-lane FIFOs into one strictly alternating stream (lane 0, lane 1, ...).
// Latency: a word written into an empty, selected lane FIFO appears on data_out two edges later. Sustained rate is 1 word/cycle.
// Backpressure: full0/full1 go to the upstream stage, and a word written into a full lane is dropped. ready_out stalls the registered output.
// Optional: define MUX_RECOMBINE_OVF_ERR_EN to build the sticky overflow flag on err. Otherwise err is tied to 0.
module mux_recombine #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in0,
  input  logic          valid_in0,
  input  logic [DW-1:0] data_in1,
  input  logic          valid_in1,
  output logic          full0,
  output logic          full1,
  input  logic          ready_out,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          sel_out,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // The state names the lane that must supply the next output word.
  localparam logic [0:0] WAIT0 = 1'b0;
  localparam logic [0:0] WAIT1 = 1'b1;

  // Per-lane views shared between the FIFOs and the output FSM
  logic [1:0]    in_vld;
  logic [DW-1:0] in_dat [2];
  logic [1:0]    lane_full;
  logic [1:0]    lane_nonempty;
  logic [1:0]    lane_pop;
  logic [DW-1:0] head_dat [2];

  assign in_vld    = {valid_in1, valid_in0};
  assign in_dat[0] = data_in0;
  assign in_dat[1] = data_in1;

  // Lane FIFOs. The full and empty decisions use only the pre-edge count.
  // A word written while full is dropped even if the same lane pops this cycle,
  // and a write into an empty FIFO cannot be popped in the same cycle.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr;

    assign lane_full[g]     = (cnt_q == CNT_FULL);
    assign lane_nonempty[g] = (cnt_q != '0);
    assign wr               = in_vld[g] & ~lane_full[g];
    assign head_dat[g]      = mem_q[rd_ptr_q];

    // Next pointers and occupancy. A write and a pop together leave the count unchanged.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (lane_pop[g]) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr, lane_pop[g]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Storage needs no reset, because the zeroed count makes stale entries unreachable.
    always_ff @(posedge clk) begin
      if (wr) begin
        mem_q[wr_ptr_q] <= in_dat[g];
      end
    end

    // Pointer and count registers. Reset discards everything buffered.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end
  end

  assign full0 = lane_full[0];
  assign full1 = lane_full[1];

  // Output stage state
  logic [0:0]    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          sel_q, sel_d;
  logic          load_en;
  logic          pop_any;

  // Output FSM: pop only from the lane named by the state and never skip it.
  // Without a pop, an accepted word empties the output register.
  always_comb begin
    load_en  = ~valid_q | ready_out;
    pop_any  = load_en & lane_nonempty[state_q];
    lane_pop = '0;
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    if (pop_any) begin
      lane_pop[state_q] = 1'b1;
      data_d            = head_dat[state_q];
      valid_d           = 1'b1;
      sel_d             = state_q[0];
      state_d           = (state_q == WAIT0) ? WAIT1 : WAIT0;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  // Registered output and FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sel_out   = sel_q;

`ifdef MUX_RECOMBINE_OVF_ERR_EN
  logic err_q, err_d;

  // Sticky overflow: any valid word offered to a full lane sets the flag until reset.
  always_comb begin
    err_d = err_q | (|(in_vld & lane_full));
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
